// File: rtl/divider_seq_if.sv
// divider_seq_if: operand/result bundle for the sequential divider.
//   start        request pulse (master -> slave)
//   dividend     16-bit unsigned numerator (master -> slave)
//   divisor      8-bit unsigned denominator (master -> slave)
//   quotient     16-bit registered result (slave -> master)
//   remainder    8-bit registered result (slave -> master)
//   busy         division in progress (slave -> master)
//   done         one-cycle completion pulse (slave -> master)
//   div_by_zero  error flag, valid with done and held (slave -> master)
interface divider_seq_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: 16/8 unsigned restoring divider, one quotient bit per clock.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    divider_seq_if.slave: start/dividend/divisor in,
//          quotient/remainder/busy/done/div_by_zero out (all registered)
// A start accepted in idle either runs 16 CALC cycles or, for a zero divisor,
// goes straight to DONE with quotient=FFFF, remainder=0 and the error flag set.
module divider_seq (
    input logic          clk,
    input logic          rst_n,
    divider_seq_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e      state_q, state_d;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [15:0] dq_q, dq_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [8:0]  prem_q, prem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] quo_q, quo_d;
    logic [7:0]  rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    // One restoring step.
    logic [9:0]  shifted;
    logic [8:0]  trial;
    logic        qbit;
    logic [8:0]  next_rem;

    always_comb begin
        shifted  = {prem_q, dq_q[15]};
        qbit     = (shifted >= {2'b00, dvs_q});
        trial    = shifted[8:0] - {1'b0, dvs_q};
        next_rem = qbit ? trial : shifted[8:0];
    end

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor == 8'd0) begin
                        state_d = StDone;
                        quo_d   = 16'hFFFF;
                        rem_d   = 8'h00;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StCalc;
                        dq_d    = bus.dividend;
                        dvs_d   = bus.divisor;
                        prem_d  = 9'd0;
                        cnt_d   = 5'd0;
                        dbz_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            StCalc: begin
                busy_d = 1'b1;
                prem_d = next_rem;
                dq_d   = {dq_q[14:0], qbit};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = StDone;
                    quo_d   = {dq_q[14:0], qbit};
                    rem_d   = next_rem[7:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dq_q    <= 16'd0;
            dvs_q   <= 8'd0;
            prem_q  <= 9'd0;
            cnt_q   <= 5'd0;
            quo_q   <= 16'd0;
            rem_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: scoreboard bench for divider_seq. The driver pushes the
// expected result and the time its done pulse should be seen; a negedge
// monitor pops and compares whenever done is high.
module tb_divider_seq;

    logic clk;
    logic rst_n;

    divider_seq_if bus ();

    divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        longint      t;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: done pulses, busy run length, scoreboard pops.
    int   busy_run = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_len", busy_run, 16);
                busy_run = 0;
            end
            if (bus.done) begin
                chk("done_width", prev_done, 0);
                chk("busy_at_done", bus.busy, 0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done seen with empty scoreboard at %0t",
                             $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_by_zero", bus.div_by_zero, e.z);
                    chk("done_time", $time, e.t);
                end
            end
            prev_done = bus.done;
        end
    end

    // Expected done sample time relative to the negedge where start is driven.
    function automatic longint done_at(input longint base, input logic [7:0] b);
        return (b == 8'd0) ? base + 10 : base + 170;
    endfunction

    task automatic push(input logic [15:0] q, input logic [7:0] r, input logic z,
                        input longint t);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        e.t = t;
        sbq.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy=%0b done=%0b never went idle", bus.busy, bus.done);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_quotient"}, bus.quotient, 0);
        chk({tag, "_remainder"}, bus.remainder, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_dbz"}, bus.div_by_zero, 0);
    endtask

    // One start pulse; operands are scrambled afterwards so a DUT that
    // reads them during CALC gets the wrong answer.
    task automatic issue(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic ez);
        wait_idle();
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        push(eq, er, ez, done_at($time, b));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint base;
        logic [15:0] a;
        logic [7:0]  b;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor  = 8'd0;
        #2;
        outs_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed vectors.
        issue(16'd50,    8'd10,  16'd5,     8'd0,   1'b0);
        issue(16'd1000,  8'd7,   16'd142,   8'd6,   1'b0);
        issue(16'd65535, 8'd255, 16'd257,   8'd0,   1'b0);
        issue(16'd5,     8'd10,  16'd0,     8'd5,   1'b0);
        issue(16'd1234,  8'd0,   16'hFFFF,  8'd0,   1'b1);
        issue(16'd50,    8'd10,  16'd5,     8'd0,   1'b0);
        issue(16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0);
        issue(16'd254,   8'd255, 16'd0,     8'd254, 1'b0);
        issue(16'd0,     8'd3,   16'd0,     8'd0,   1'b0);
        issue(16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1);
        issue(16'd255,   8'd255, 16'd1,     8'd0,   1'b0);

        // Start re-pulsed mid-CALC must be ignored.
        issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        repeat (7) @(negedge clk);
        bus.dividend = 16'd9999;
        bus.divisor  = 8'd0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;

        // Back-to-back with start held high: 18-cycle issue interval.
        wait_idle();
        base         = $time;
        bus.dividend = 16'd60000;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        push(16'd8571, 8'd3, 1'b0, base + 170);
        push(16'd8571, 8'd3, 1'b0, base + 350);
        repeat (20) @(negedge clk);
        bus.start    = 1'b0;

        // Reset mid-CALC aborts; start on the release edge is accepted.
        issue(16'd60000, 8'd7, 16'd8571, 8'd3, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        void'(sbq.pop_back());
        #1;
        outs_zero("abort");
        @(negedge clk);
        #2;
        base         = $time - 2;
        rst_n        = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor  = 8'd3;
        bus.start    = 1'b1;
        push(16'd66, 8'd2, 1'b0, base + 170);
        @(negedge clk);
        bus.start    = 1'b0;

        // Random operands against the integer reference.
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            issue(a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameters: none; widths fixed at a 16-bit dividend and an 8-bit divisor.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
REQ-003 start  input  1  request pulse; sampled on rising clk.
REQ-004 dividend  input  16  unsigned numerator; sampled only when start is accepted.
REQ-005 divisor  input  8  unsigned denominator; sampled only when start is accepted.
REQ-006 quotient  output  16  registered unsigned result.
REQ-007 remainder  output  8  registered unsigned result.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 div_by_zero  output  1  error flag; valid while done=1 and held afterwards.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE.
REQ-012 start SHALL be accepted only in IDLE; start in CALC or DONE SHALL be ignored, with no effect on operands, counter or outputs.
REQ-013 On an accepted start with divisor!=0 at edge N, the block SHALL do the following:
- latch dividend and divisor;
- clear the 9-bit partial remainder and the 5-bit iteration counter;
- clear div_by_zero;
- move to CALC.
REQ-014 Each CALC cycle SHALL run one restoring-division step, MSB first:
- shift the partial remainder left and bring in the next dividend bit;
- trial-subtract the divisor using 9-bit arithmetic;
- if the result is non-negative, keep it and shift in quotient bit 1;
- otherwise restore the remainder and shift in quotient bit 0.
REQ-015 CALC SHALL last exactly 16 cycles (edges N+1..N+16); at edge N+16 quotient and remainder outputs SHALL be loaded and the FSM SHALL move to DONE.
REQ-016 done SHALL be high for exactly one cycle, from edge N+16 to edge N+17; DONE SHALL then return to IDLE unconditionally.
REQ-017 busy SHALL be high from edge N to edge N+16 (CALC state only), and low in IDLE and DONE.
REQ-018 Divide-by-zero: on an accepted start with divisor==0 at edge N, the block SHALL do the following:
- go directly to DONE;
- load quotient=16'hFFFF and remainder=8'h00;
- set div_by_zero=1.
done is then high edge N to N+1, and busy stays low.
REQ-019 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values until the next completion; div_by_zero SHALL also clear on the next accepted start.
REQ-021 Input changes to dividend or divisor during CALC SHALL NOT affect the result.
REQ-022 Back-to-back operation: a start held high continuously SHALL be accepted in the first IDLE cycle after DONE, giving a minimum issue interval of 18 cycles.
REQ-023 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-024 While rst_n=0 the block SHALL asynchronously force the following:
- state to IDLE;
- quotient to 16'h0000 and remainder to 8'h00;
- busy, done and div_by_zero to 0;
- the counter and partial remainder to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after rst_n deasserts, the first start SHALL be accepted normally.
REQ-026 Deassertion of rst_n SHALL take effect at the next rising clk; start sampled on that edge SHALL be accepted.

Verification
REQ-027 dividend=50, divisor=10 -> done at start edge+16, quotient=5, remainder=0, div_by_zero=0, busy high for 16 cycles.
REQ-028 Three directed divisions -> each result correct and each done a single-cycle pulse:
- dividend=1000, divisor=7 -> quotient=142, remainder=6;
- dividend=65535, divisor=255 -> quotient=257, remainder=0;
- dividend=5, divisor=10 -> quotient=0, remainder=5.
REQ-029 dividend=1234, divisor=0 -> done one cycle after start, quotient=16'hFFFF, remainder=0, div_by_zero=1, busy never high.
REQ-030 start re-pulsed with new operands at CALC cycle 8 -> ignored; the original result is delivered on schedule.
REQ-031 rst_n pulsed low at CALC cycle 5 -> all outputs 0 immediately with no done pulse; a subsequent division of 200 by 3 -> quotient=66, remainder=2.
REQ-032 Random self-check, at least 1000 random operand pairs with divisor!=0 -> quotient and remainder match the integer / and % reference every run.
